// File: rtl/uart_tx_arb.sv
// Round-robin sequencer that shares one UART transmitter among N_REQ clients,
// with an enforced inter-frame gap and a watchdog that aborts a hung frame.
module uart_tx_arb #(
  parameter int N_REQ       = 4,
  parameter int DW          = 9,
  parameter int BPS_CNT     = 434,
  parameter int GAP_CYC     = BPS_CNT,
  parameter int TIMEOUT_CYC = BPS_CNT * 12,
  localparam int IDW        = $clog2(N_REQ)
) (
  input  logic                  uclk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      gnt,
  output logic                  tx_start,
  output logic [DW-1:0]         tx_data,
  input  logic                  tx_done,
  output logic [IDW-1:0]        cur_id,
  output logic                  arb_busy,
  output logic                  timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_lastGnt;
  logic [CW-1:0]  r_cnt;

  logic [DW-1:0]  w_reqWords [N_REQ];
  logic           w_anyReq;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  logic [DW-1:0]  w_winData;
  logic [CW-1:0]  w_cntNext;
  int             w_sum;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign w_reqWords[g] = req_data[g*DW +: DW];
  end

  assign w_cntNext = r_cnt + CW'(1);

  // Search starts one past the last winner and wraps, so every active client
  // is reached within N_REQ frames.
  always_comb begin
    w_anyReq  = 1'b0;
    w_win     = '0;
    w_winData = '0;
    w_sum     = 0;
    w_idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = int'(r_lastGnt) + k;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      w_idx = IDW'(w_sum);
      if (!w_anyReq && req[w_idx]) begin
        w_anyReq  = 1'b1;
        w_win     = w_idx;
        w_winData = w_reqWords[w_idx];
      end
    end
  end

  always_ff @(posedge uclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_lastGnt   <= IDW'(N_REQ - 1);
      r_cnt       <= '0;
      gnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      cur_id      <= '0;
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      gnt         <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            cur_id    <= w_win;
            r_lastGnt <= w_win;
            tx_data   <= w_winData;
            gnt       <= N_REQ'(1) << w_win;
            tx_start  <= 1'b1;
            arb_busy  <= 1'b1;
            r_state   <= START;
          end
        end
        START: begin
          r_cnt   <= '0;
          r_state <= WAIT_DONE;
        end
        // The abort is decided on the edge the count reaches its terminal
        // value, so the pulse lands TIMEOUT_CYC cycles after tx_start; a
        // tx_done sampled on that same edge wins.
        WAIT_DONE: begin
          r_cnt <= w_cntNext;
          if (tx_done || (w_cntNext == CW'(TIMEOUT_CYC - 1))) begin
            timeout_err <= ~tx_done;
            r_cnt       <= '0;
            if (GAP_CYC == 0) begin
              r_state  <= IDLE;
              arb_busy <= 1'b0;
            end else begin
              r_state <= GAP;
            end
          end
        end
        GAP: begin
          if (r_cnt == CW'(GAP_CYC - 1)) begin
            r_cnt    <= '0;
            r_state  <= IDLE;
            arb_busy <= 1'b0;
          end else begin
            r_cnt <= w_cntNext;
          end
        end
        default: begin
          r_state  <= IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb at default parameters (gap 434, timeout 5208);
// every check is timed in whole cycles counted from the tx_start cycle.
module tb_uart_tx_arb;

  localparam int N_REQ = 4;
  localparam int DW    = 9;

  logic                uclk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] reqData;
  logic [N_REQ-1:0]    gnt;
  logic                txStart;
  logic [DW-1:0]       txData;
  logic                txDone;
  logic [1:0]          curId;
  logic                arbBusy;
  logic                timeoutErr;

  int totalChecks = 0;
  int badChecks   = 0;

  always #10 uclk = ~uclk;

  uart_tx_arb dut (
    .uclk        (uclk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (reqData),
    .gnt         (gnt),
    .tx_start    (txStart),
    .tx_data     (txData),
    .tx_done     (txDone),
    .cur_id      (curId),
    .arb_busy    (arbBusy),
    .timeout_err (timeoutErr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge uclk);
      #1;
    end
  endtask

  // Inputs are driven in the current cycle, then n edges pass; the caller
  // lands #1 after the n-th edge.
  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic d, input int n);
    req    = r;
    txDone = d;
    step(n);
  endtask

  task automatic setWord(input int i, input logic [DW-1:0] w);
    reqData[i*DW +: DW] = w;
  endtask

  task automatic doReset;
    rst_n  = 1'b0;
    req    = '0;
    txDone = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int expGnt;
    req     = '0;
    txDone  = 1'b0;
    reqData = '0;

    // Reset values
    step(2);
    checkOutput("rst gnt",      32'(gnt),        32'h0);
    checkOutput("rst txStart",  32'(txStart),    32'h0);
    checkOutput("rst txData",   32'(txData),     32'h0);
    checkOutput("rst curId",    32'(curId),      32'h0);
    checkOutput("rst arbBusy",  32'(arbBusy),    32'h0);
    checkOutput("rst timeout",  32'(timeoutErr), 32'h0);
    rst_n = 1'b1;
    step(1);

    // T1: single requester, done at +4340, then a 434-cycle gap
    setWord(1, 9'h0A5);
    applyStimulus(4'b0010, 1'b0, 1);
    checkOutput("t1 txStart", 32'(txStart), 32'h1);
    checkOutput("t1 gnt",     32'(gnt),     32'h2);
    checkOutput("t1 txData",  32'(txData),  32'h0A5);
    checkOutput("t1 curId",   32'(curId),   32'h1);
    checkOutput("t1 arbBusy", 32'(arbBusy), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1);
    checkOutput("t1 start pulse", 32'(txStart), 32'h0);
    checkOutput("t1 gnt pulse",   32'(gnt),     32'h0);
    applyStimulus(4'b0000, 1'b0, 4339);
    applyStimulus(4'b0000, 1'b1, 1);
    applyStimulus(4'b0000, 1'b0, 433);
    checkOutput("t1 busy in gap", 32'(arbBusy), 32'h1);
    checkOutput("t1 data held",   32'(txData),  32'h0A5);
    applyStimulus(4'b0000, 1'b0, 1);
    checkOutput("t1 busy falls",  32'(arbBusy), 32'h0);

    // T2: all four requesting, round-robin from requester 0
    doReset();
    for (int i = 0; i < N_REQ; i++) setWord(i, 9'(9'h100 + i));
    applyStimulus(4'b1111, 1'b0, 1);
    for (int f = 0; f < 5; f++) begin
      expGnt = 1 << (f % 4);
      checkOutput($sformatf("t2 f%0d txStart", f), 32'(txStart), 32'h1);
      checkOutput($sformatf("t2 f%0d gnt", f),     32'(gnt),     32'(expGnt));
      checkOutput($sformatf("t2 f%0d txData", f),  32'(txData),  32'h100 + 32'(f % 4));
      applyStimulus(4'b1111, 1'b0, 3);
      applyStimulus(4'b1111, 1'b1, 1);
      if (f < 4) applyStimulus(4'b1111, 1'b0, 435);
      else       applyStimulus(4'b0000, 1'b0, 434);
    end
    checkOutput("t2 idle busy", 32'(arbBusy), 32'h0);

    // T3: requester 2, tx_done never comes
    setWord(2, 9'h1C3);
    applyStimulus(4'b0100, 1'b0, 1);
    checkOutput("t3 curId",   32'(curId),   32'h2);
    checkOutput("t3 txStart", 32'(txStart), 32'h1);
    applyStimulus(4'b0000, 1'b0, 5207);
    checkOutput("t3 no early timeout", 32'(timeoutErr), 32'h0);
    applyStimulus(4'b0000, 1'b0, 1);
    checkOutput("t3 timeout at 5208",  32'(timeoutErr), 32'h1);
    checkOutput("t3 busy at timeout",  32'(arbBusy),    32'h1);
    applyStimulus(4'b0001, 1'b0, 1);
    checkOutput("t3 timeout pulse",    32'(timeoutErr), 32'h0);
    applyStimulus(4'b0001, 1'b0, 433);
    checkOutput("t3 no grant in gap",  32'(txStart),    32'h0);
    applyStimulus(4'b0001, 1'b0, 1);
    checkOutput("t3 next txStart",     32'(txStart),    32'h1);
    checkOutput("t3 next curId",       32'(curId),      32'h0);
    applyStimulus(4'b0000, 1'b0, 2);
    applyStimulus(4'b0000, 1'b1, 1);
    applyStimulus(4'b0000, 1'b0, 434);
    checkOutput("t3 idle busy", 32'(arbBusy), 32'h0);

    // T4: reset while waiting on requester 3's frame
    setWord(3, 9'h155);
    setWord(0, 9'h02A);
    applyStimulus(4'b1000, 1'b0, 1);
    checkOutput("t4 curId 3", 32'(curId), 32'h3);
    applyStimulus(4'b0000, 1'b0, 5);
    rst_n = 1'b0;
    #2;
    checkOutput("t4 async busy",   32'(arbBusy), 32'h0);
    checkOutput("t4 async txData", 32'(txData),  32'h0);
    checkOutput("t4 async curId",  32'(curId),   32'h0);
    req = 4'b1001;
    step(2);
    rst_n = 1'b1;
    step(1);
    checkOutput("t4 req0 first curId", 32'(curId),  32'h0);
    checkOutput("t4 req0 first gnt",   32'(gnt),    32'h1);
    checkOutput("t4 req0 txData",      32'(txData), 32'h02A);
    applyStimulus(4'b0000, 1'b0, 2);
    applyStimulus(4'b0000, 1'b1, 1);
    applyStimulus(4'b0000, 1'b0, 434);
    checkOutput("t4 idle busy", 32'(arbBusy), 32'h0);

    // T5: one-cycle request is still sent; spurious tx_done in GAP and IDLE
    setWord(2, 9'h0F0);
    applyStimulus(4'b0100, 1'b0, 1);
    checkOutput("t5 pulse txStart", 32'(txStart), 32'h1);
    checkOutput("t5 pulse curId",   32'(curId),   32'h2);
    checkOutput("t5 pulse txData",  32'(txData),  32'h0F0);
    applyStimulus(4'b0000, 1'b0, 3);
    applyStimulus(4'b0000, 1'b1, 1);
    applyStimulus(4'b0000, 1'b0, 6);
    applyStimulus(4'b0000, 1'b1, 1);
    applyStimulus(4'b0000, 1'b0, 9);
    applyStimulus(4'b0010, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 416);
    checkOutput("t5 gap length kept", 32'(arbBusy), 32'h1);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("t5 idle reached",    32'(arbBusy), 32'h0);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("t5 done in idle busy",  32'(arbBusy), 32'h0);
    checkOutput("t5 done in idle start", 32'(txStart), 32'h0);
    applyStimulus(4'b0000, 1'b0, 2);
    checkOutput("t5 dropped req unserved", 32'(arbBusy), 32'h0);

    // T6: tx_done sampled on the watchdog's terminal edge
    applyStimulus(4'b0001, 1'b0, 1);
    checkOutput("t6 curId", 32'(curId), 32'h0);
    applyStimulus(4'b0000, 1'b0, 5207);
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("t6 no timeout",  32'(timeoutErr), 32'h0);
    checkOutput("t6 busy in gap", 32'(arbBusy),    32'h1);
    applyStimulus(4'b0000, 1'b0, 1);
    checkOutput("t6 still no timeout", 32'(timeoutErr), 32'h0);
    applyStimulus(4'b0000, 1'b0, 432);
    checkOutput("t6 gap end busy", 32'(arbBusy), 32'h1);
    applyStimulus(4'b0000, 1'b0, 1);
    checkOutput("t6 idle after gap", 32'(arbBusy), 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
